pulse_sequencer: RTL and testbench

//  Parametrised machine-cycle phase sequencer; generalises the fixed 8-phase pulse controller.

---
 rtl/pulse_sequencer_pkg.sv | 16 +
 rtl/pulse_sequencer_next_sel.sv | 35 +++
 rtl/pulse_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_pulse_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_sequencer_pkg.sv
// Shared definitions for the machine-cycle phase sequencer:
// FSM state encoding and default sizing constants.
package pulse_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } seq_state_t;

    localparam int DEF_N_PHASE = 8;
    localparam int DEF_TMO_W   = 8;
    localparam int DEF_TMO_CYC = 200;

endpackage

// File: rtl/pulse_sequencer_next_sel.sv
// Skip-aware next-phase finder: returns the first phase after `cur`
// (cyclically) whose skip bit is clear. Phase 0 is never skipped, so a
// result always exists; wrap flags a return to phase 0.
module pulse_next_sel
    import pulse_sequencer_pkg::*;
#(
    parameter int N_PHASE = DEF_N_PHASE,
    parameter int PH_W    = $clog2(N_PHASE)
) (
    input  logic [PH_W-1:0]    cur,
    input  logic [N_PHASE-1:0] skip,
    output logic [PH_W-1:0]    nxt,
    output logic               wrap
);

    logic            w_found;
    logic [PH_W-1:0] w_idx;

    // Scan forward from cur+1; first non-skipped index (or phase 0) wins.
    always_comb begin
        nxt     = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k < N_PHASE; k++) begin
            w_idx = PH_W'((int'(cur) + k) % N_PHASE);
            if (!w_found && ((w_idx == '0) || !skip[w_idx])) begin
                nxt     = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign wrap = (nxt == '0);

endmodule

// File: rtl/pulse_sequencer.sv
// Machine-cycle phase sequencer. Steps through N_PHASE phases, holding each
// until its phase_done bit, with skippable phases, single-step pausing,
// stop at the end of a machine cycle and a per-phase watchdog.
// All control inputs are sampled on the rising edge: do_start, do_stop,
// step_req and fault_clr are one-cycle pulses, step_mode is a level, and
// phase_skip only matters at the moment a phase completes.
module pulse_sequencer
    import pulse_sequencer_pkg::*;
#(
    parameter int N_PHASE = DEF_N_PHASE,
    parameter int PH_W    = $clog2(N_PHASE),
    parameter int TMO_W   = DEF_TMO_W,
    parameter int TMO_CYC = DEF_TMO_CYC
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               do_start,
    input  logic               do_stop,
    input  logic               step_mode,
    input  logic               step_req,
    input  logic               fault_clr,
    input  logic [N_PHASE-1:0] phase_skip,
    input  logic [N_PHASE-1:0] phase_done,
    output logic [PH_W-1:0]    cur_phase,
    output logic [N_PHASE-1:0] phase_active,
    output logic [N_PHASE-1:0] phase_enter,
    output logic               cycle_end,
    output logic               running,
    output logic               timeout_err,
    output logic [PH_W-1:0]    fault_phase,
    output logic [1:0]         dbg_state
);

    // Watchdog compare value: the count reached on the TMO_CYC-th idle cycle.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TMO_CYC > 0) ? (TMO_CYC - 1) : 0);

    seq_state_t         r_state, w_state_n;
    logic [PH_W-1:0]    r_cur, w_cur_n;
    logic [PH_W-1:0]    r_hold_nxt, w_hold_nxt_n;
    logic               r_stop_pend, w_stop_pend_n;
    logic [TMO_W-1:0]   r_wdog, w_wdog_n;
    logic [N_PHASE-1:0] r_active, w_active_n;
    logic [N_PHASE-1:0] r_enter, w_enter_n;
    logic               r_cycle_end, w_cycle_end_n;
    logic               r_running, w_running_n;
    logic               r_tmo, w_tmo_n;
    logic [PH_W-1:0]    r_fault_phase, w_fault_phase_n;

    logic [PH_W-1:0]    w_nxt;
    logic               w_wrap;
    logic               w_done;

    function automatic logic [N_PHASE-1:0] onehot(input logic [PH_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    pulse_next_sel #(
        .N_PHASE (N_PHASE),
        .PH_W    (PH_W)
    ) u_next_sel (
        .cur  (r_cur),
        .skip (phase_skip),
        .nxt  (w_nxt),
        .wrap (w_wrap)
    );

    assign w_done = phase_done[r_cur];

    // Next-state, watchdog and next-output decode; outputs are registered below.
    always_comb begin
        w_state_n       = r_state;
        w_cur_n         = r_cur;
        w_hold_nxt_n    = r_hold_nxt;
        w_stop_pend_n   = r_stop_pend;
        w_wdog_n        = r_wdog;
        w_active_n      = '0;
        w_enter_n       = '0;
        w_cycle_end_n   = 1'b0;
        w_fault_phase_n = r_fault_phase;
        case (r_state)
            ST_IDLE: begin
                // A stop arriving with the start cancels it.
                if (do_start && !do_stop) begin
                    w_state_n  = ST_RUN;
                    w_cur_n    = '0;
                    w_wdog_n   = '0;
                    w_enter_n  = onehot('0);
                    w_active_n = onehot('0);
                end
            end
            ST_RUN: begin
                w_active_n = onehot(r_cur);
                if (do_stop) w_stop_pend_n = 1'b1;
                if (w_done) begin
                    // Completion always beats a watchdog expiry in the same cycle.
                    w_cycle_end_n = w_wrap;
                    w_wdog_n      = '0;
                    if (w_wrap && (r_stop_pend || do_stop)) begin
                        w_state_n     = ST_IDLE;
                        w_cur_n       = '0;
                        w_stop_pend_n = 1'b0;
                        w_active_n    = '0;
                    end else if (step_mode) begin
                        w_state_n    = ST_HOLD;
                        w_hold_nxt_n = w_nxt;
                        w_active_n   = '0;
                    end else begin
                        w_cur_n    = w_nxt;
                        w_enter_n  = onehot(w_nxt);
                        w_active_n = onehot(w_nxt);
                    end
                end else if (TMO_CYC != 0) begin
                    if (r_wdog == TMO_LAST) begin
                        w_state_n       = ST_FAULT;
                        w_fault_phase_n = r_cur;
                        w_active_n      = '0;
                        w_stop_pend_n   = 1'b0;
                        w_wdog_n        = '0;
                    end else begin
                        w_wdog_n = r_wdog + TMO_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                // Paused between phases: cur_phase still names the finished phase.
                if (do_stop) w_stop_pend_n = 1'b1;
                if (step_req || !step_mode) begin
                    w_state_n  = ST_RUN;
                    w_cur_n    = r_hold_nxt;
                    w_wdog_n   = '0;
                    w_enter_n  = onehot(r_hold_nxt);
                    w_active_n = onehot(r_hold_nxt);
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    w_state_n = ST_IDLE;
                    w_cur_n   = '0;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_cur_n   = '0;
            end
        endcase
        w_running_n = (w_state_n == ST_RUN) || (w_state_n == ST_HOLD);
        w_tmo_n     = (w_state_n == ST_FAULT);
    end

    // State, bookkeeping and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_cur         <= '0;
            r_hold_nxt    <= '0;
            r_stop_pend   <= 1'b0;
            r_wdog        <= '0;
            r_active      <= '0;
            r_enter       <= '0;
            r_cycle_end   <= 1'b0;
            r_running     <= 1'b0;
            r_tmo         <= 1'b0;
            r_fault_phase <= '0;
        end else begin
            r_state       <= w_state_n;
            r_cur         <= w_cur_n;
            r_hold_nxt    <= w_hold_nxt_n;
            r_stop_pend   <= w_stop_pend_n;
            r_wdog        <= w_wdog_n;
            r_active      <= w_active_n;
            r_enter       <= w_enter_n;
            r_cycle_end   <= w_cycle_end_n;
            r_running     <= w_running_n;
            r_tmo         <= w_tmo_n;
            r_fault_phase <= w_fault_phase_n;
        end
    end

    assign cur_phase    = r_cur;
    assign phase_active = r_active;
    assign phase_enter  = r_enter;
    assign cycle_end    = r_cycle_end;
    assign running      = r_running;
    assign timeout_err  = r_tmo;
    assign fault_phase  = r_fault_phase;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer: expected phase_enter order queued per scenario
// and matched as strobes appear, a per-cycle table for single-step mode, and
// hand-written sequences for stop, watchdog and reset corners.
module tb_pulse_sequencer;

    logic       clk;
    logic       resetn;
    logic       do_start, do_stop, step_mode, step_req, fault_clr;
    logic [7:0] phase_skip, phase_done, phase_active, phase_enter;
    logic [2:0] cur_phase, fault_phase;
    logic       cycle_end, running, timeout_err;
    logic [1:0] dbg_state;

    // phase_done source: automatic responder (done 2 cycles after entry) or manual.
    logic       gen_en;
    logic [7:0] gen_done, man_done;
    int         gen_cnt;
    assign phase_done = gen_en ? gen_done : man_done;

    logic       mon_en;
    logic [7:0] exp_q[$];
    int         exp_gap, last_enter, cyc;
    bit         mon_first;
    int         total, bad;

    typedef struct {
        logic       start, mode, req;
        logic       run;
        logic [7:0] act, ent;
        logic [2:0] cur;
        logic       ce;
    } vec_t;
    vec_t tbl[15];

    pulse_sequencer #(
        .N_PHASE (8),
        .PH_W    (3),
        .TMO_W   (8),
        .TMO_CYC (10)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .do_start     (do_start),
        .do_stop      (do_stop),
        .step_mode    (step_mode),
        .step_req     (step_req),
        .fault_clr    (fault_clr),
        .phase_skip   (phase_skip),
        .phase_done   (phase_done),
        .cur_phase    (cur_phase),
        .phase_active (phase_active),
        .phase_enter  (phase_enter),
        .cycle_end    (cycle_end),
        .running      (running),
        .timeout_err  (timeout_err),
        .fault_phase  (fault_phase),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic monitor_sample();
        logic [7:0] e;
        if (!mon_en) begin
            mon_first = 1'b1;
        end else if (phase_enter != 8'h00) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL enter_extra: got %0h want none", phase_enter);
            end else begin
                e = exp_q.pop_front();
                check("enter_seq", phase_enter, e);
            end
            if (!mon_first && exp_gap != 0) check("enter_gap", cyc - last_enter, exp_gap);
            mon_first  = 1'b0;
            last_enter = cyc;
        end
    endtask

    task automatic drive_gen();
        if (phase_enter != 8'h00) gen_cnt = 1;
        else if (phase_active != 8'h00) gen_cnt++;
        else gen_cnt = 0;
        gen_done = (phase_active != 8'h00 && gen_cnt >= 3) ? phase_active : 8'h00;
    endtask

    // One clock: observe on the falling edge, then settle inputs for the next rise.
    task automatic step();
        @(negedge clk);
        cyc++;
        monitor_sample();
        drive_gen();
        #1;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        do_start = 1'b0; do_stop = 1'b0; step_mode = 1'b0; step_req = 1'b0; fault_clr = 1'b0;
        phase_skip = 8'h00; man_done = 8'h00; gen_en = 1'b0; mon_en = 1'b0; exp_gap = 0;
        exp_q.delete();
        step();
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic pulse_start();
        do_start = 1'b1;
        step();
        do_start = 1'b0;
    endtask

    task automatic run_until_drained(input int limit);
        for (int i = 0; i < limit && exp_q.size() > 0; i++) step();
    endtask

    initial begin
        int ce_cnt;
        logic [7:0] seen;
        bit found;

        total = 0; bad = 0; cyc = 0; gen_cnt = 0; gen_done = 8'h00;
        last_enter = 0; mon_first = 1'b1;

        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h02, 8'h02, 3'd1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 3'd1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h04, 8'h04, 3'd2, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 3'd2, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 3'd2, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h08, 8'h08, 3'd3, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 3'd3, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 8'h10, 3'd4, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 8'h20, 3'd5, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 8'h40, 3'd6, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 8'h80, 3'd7, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 3'd0, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0};

        // Reset values
        apply_reset();
        check("rst_running", running, 1'b0);
        check("rst_tmo", timeout_err, 1'b0);
        check("rst_active", phase_active, 8'h00);
        check("rst_enter", phase_enter, 8'h00);
        check("rst_cycle_end", cycle_end, 1'b0);
        check("rst_cur", cur_phase, 3'd0);
        check("rst_fault_phase", fault_phase, 3'd0);
        check("rst_state", dbg_state, 2'd0);

        // Free-running, no skips: 0..7 twice then 0, three cycles per phase
        apply_reset();
        gen_en = 1'b1; exp_gap = 3;
        for (int n = 0; n < 17; n++) exp_q.push_back(8'h01 << (n % 8));
        mon_en = 1'b1;
        ce_cnt = 0;
        pulse_start();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
            step();
            if (cycle_end) begin
                ce_cnt++;
                check("t1_ce_at_wrap", phase_enter, 8'h01);
            end
        end
        check("t1_drained", exp_q.size(), 0);
        check("t1_ce_count", ce_cnt, 2);
        check("t1_running", running, 1'b1);

        // Skipped phases 2 and 5
        apply_reset();
        gen_en = 1'b1; exp_gap = 3; phase_skip = 8'b0010_0100;
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h08);
        exp_q.push_back(8'h10); exp_q.push_back(8'h40); exp_q.push_back(8'h80);
        exp_q.push_back(8'h01);
        mon_en = 1'b1;
        seen = 8'h00;
        pulse_start();
        seen |= phase_enter;
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) begin
            step();
            seen |= phase_enter;
        end
        check("t2_drained", exp_q.size(), 0);
        check("t2_skipped_never", seen & 8'h24, 8'h00);
        check("t2_seen", seen, 8'hDB);

        // Stop requested in phase 4 completes the machine cycle then idles
        apply_reset();
        gen_en = 1'b1; exp_gap = 3;
        for (int n = 0; n < 8; n++) exp_q.push_back(8'h01 << n);
        mon_en = 1'b1;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (phase_enter == 8'h10) found = 1'b1;
        end
        check("t3_reach_p4", found, 1'b1);
        do_stop = 1'b1;
        step();
        do_stop = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (cycle_end) found = 1'b1;
        end
        check("t3_cycle_end", found, 1'b1);
        check("t3_running_at_end", running, 1'b0);
        check("t3_active_at_end", phase_active, 8'h00);
        for (int i = 0; i < 4; i++) step();
        check("t3_still_idle", running, 1'b0);
        check("t3_drained", exp_q.size(), 0);

        // Single-step mode, cycle by cycle
        apply_reset();
        man_done = 8'hFF; step_mode = 1'b1;
        pulse_start();
        check("t4_first_enter", phase_enter, 8'h01);
        check("t4_first_cur", cur_phase, 3'd0);
        for (int i = 0; i < 15; i++) begin
            do_start = tbl[i].start; step_mode = tbl[i].mode; step_req = tbl[i].req;
            step();
            do_start = 1'b0; step_req = 1'b0;
            check($sformatf("t4_r%0d_run", i), running, tbl[i].run);
            check($sformatf("t4_r%0d_act", i), phase_active, tbl[i].act);
            check($sformatf("t4_r%0d_ent", i), phase_enter, tbl[i].ent);
            check($sformatf("t4_r%0d_cur", i), cur_phase, tbl[i].cur);
            check($sformatf("t4_r%0d_ce", i), cycle_end, tbl[i].ce);
        end
        step_mode = 1'b0;

        // Watchdog: phase 3 never completes, fault after 10 cycles in it
        apply_reset();
        man_done = 8'hF7;
        pulse_start();
        for (int i = 0; i < 3; i++) step();
        check("t5_enter_p3", phase_enter, 8'h08);
        for (int i = 0; i < 9; i++) step();
        check("t5_pre_running", running, 1'b1);
        check("t5_pre_active", phase_active, 8'h08);
        check("t5_pre_tmo", timeout_err, 1'b0);
        step();
        check("t5_tmo", timeout_err, 1'b1);
        check("t5_fault_phase", fault_phase, 3'd3);
        check("t5_running", running, 1'b0);
        check("t5_active", phase_active, 8'h00);
        check("t5_state", dbg_state, 2'd3);
        man_done = 8'hFF;
        step();
        step();
        check("t5_tmo_held", timeout_err, 1'b1);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("t5_clr_tmo", timeout_err, 1'b0);
        check("t5_clr_running", running, 1'b0);
        check("t5_clr_cur", cur_phase, 3'd0);
        check("t5_clr_fault_phase", fault_phase, 3'd3);

        // Completion in the expiry cycle advances instead of faulting
        apply_reset();
        man_done = 8'hF7;
        pulse_start();
        for (int i = 0; i < 3; i++) step();
        for (int i = 0; i < 9; i++) step();
        man_done = 8'hFF;
        step();
        check("t6_race_tmo", timeout_err, 1'b0);
        check("t6_race_cur", cur_phase, 3'd4);
        check("t6_race_enter", phase_enter, 8'h10);

        // Asynchronous reset in the middle of phase 5
        apply_reset();
        gen_en = 1'b1;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (phase_enter == 8'h20) found = 1'b1;
        end
        check("t6_reach_p5", found, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        check("t6_rst_running", running, 1'b0);
        check("t6_rst_active", phase_active, 8'h00);
        check("t6_rst_enter", phase_enter, 8'h00);
        check("t6_rst_cur", cur_phase, 3'd0);
        step();
        check("t6_rst_no_ce", cycle_end, 1'b0);
        step();
        check("t6_rst_no_ce2", cycle_end, 1'b0);

        // Start and stop together in IDLE: stop wins
        apply_reset();
        do_start = 1'b1; do_stop = 1'b1;
        step();
        do_start = 1'b0; do_stop = 1'b0;
        check("t6_ss_running", running, 1'b0);
        check("t6_ss_enter", phase_enter, 8'h00);
        step();
        check("t6_ss_state", dbg_state, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "bench timeout");
    end

endmodule
